// File: rtl/seg_pkg.sv
// Shared seven-segment definitions.
// Segment patterns are stored active-low, bit6..0 = a..g, which matches
// the board pins; blocks driving active-high displays invert at their outputs.
package seg_pkg;

    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100   // 9
    };
    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Width of a digit index for an n-digit display (at least one bit).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Bus between a BCD-producing core and the scan multiplexer.
// master: the core side (drives digits and masks, observes pins).
// slave : the multiplexer (consumes digits and masks, drives pins).
//   bcd_in      4*N_DIGITS  digit i = bcd_in[4i+3:4i], digit N_DIGITS-1 leftmost
//   dp_mask     N_DIGITS    decimal point lit on digit i
//   blank_mask  N_DIGITS    digit i forced dark
//   blink_mask  N_DIGITS    digit i dark during blink phase 1
//   lz_en       1           leading-zero suppression enable
//   seg/dot/an              segment, decimal point and anode pins
//   frame_start 1           one-cycle pulse when a new snapshot is taken
interface seg_scan_mux_if #(
    parameter int N_DIGITS = 4
) ();
    logic [4*N_DIGITS-1:0] bcd_in;
    logic [N_DIGITS-1:0]   dp_mask;
    logic [N_DIGITS-1:0]   blank_mask;
    logic [N_DIGITS-1:0]   blink_mask;
    logic                  lz_en;
    logic [6:0]            seg;
    logic                  dot;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_start;

    modport master (
        output bcd_in, dp_mask, blank_mask, blink_mask, lz_en,
        input  seg, dot, an, frame_start
    );

    modport slave (
        input  bcd_in, dp_mask, blank_mask, blink_mask, lz_en,
        output seg, dot, an, frame_start
    );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder, active-low abcdefg.
// Values 10..15 show a dash (segment g only).
//   bcd_i  4  input digit
//   seg_o  7  active-low segment pattern, bit6..0 = a..g
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = SEG_DIGIT[0];
            4'd1: seg_o = SEG_DIGIT[1];
            4'd2: seg_o = SEG_DIGIT[2];
            4'd3: seg_o = SEG_DIGIT[3];
            4'd4: seg_o = SEG_DIGIT[4];
            4'd5: seg_o = SEG_DIGIT[5];
            4'd6: seg_o = SEG_DIGIT[6];
            4'd7: seg_o = SEG_DIGIT[7];
            4'd8: seg_o = SEG_DIGIT[8];
            4'd9: seg_o = SEG_DIGIT[9];
            default: seg_o = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seg_scan_mux.sv
// N-digit seven-segment scan multiplexer.
// One digit is driven per clk_17 cycle, leftmost first. Inputs are captured
// into shadow registers once per frame so a frame never mixes two values.
// Supports leading-zero suppression, per-digit blanking, decimal points and
// blinking. All pin outputs are registered (one cycle behind the scan index).
//   clk_17  1  scan clock
//   rst     1  asynchronous reset, active-high
//   bus_if     slave side of seg_scan_mux_if (digits/masks in, pins out)
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int BLINK_FRAMES = 32,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic           clk_17,
    input  logic           rst,
    seg_scan_mux_if.slave  bus_if
);
    localparam int IW = idx_w(N_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IW-1:0] IDX_TOP    = IW'(N_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic          INACT      = (ACTIVE_LOW != 0);

    // Scan and blink control
    logic [IW-1:0]         idx_q;
    logic [FW-1:0]         frame_cnt_q;
    logic                  phase_q;
    logic                  fs_q;

    // Per-frame snapshot of the inputs
    logic [4*N_DIGITS-1:0] bcd_q;
    logic [N_DIGITS-1:0]   dp_q;
    logic [N_DIGITS-1:0]   blank_q;
    logic [N_DIGITS-1:0]   blink_q;
    logic                  lz_q;

    // Pin registers
    logic [6:0]            seg_q, seg_d;
    logic                  dot_q, dot_d;
    logic [N_DIGITS-1:0]   an_q, an_d;

    logic [3:0]            digit;
    logic [6:0]            dec;
    logic [N_DIGITS-1:0]   lead_zero;
    logic                  dark;
    logic                  wrap;

    bcd_to_seg u_dec (
        .bcd_i (digit),
        .seg_o (dec)
    );

    assign wrap = (idx_q == '0);

    always_comb begin
        logic acc;
        digit = bcd_q[4*int'(idx_q) +: 4];

        // lead_zero[i]: every shadow digit from the leftmost down to i is zero.
        acc = 1'b1;
        lead_zero = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            acc = acc & (bcd_q[4*i +: 4] == 4'd0);
            lead_zero[i] = acc;
        end

        // The units digit is exempt from suppression so a zero value still shows "0".
        dark = blank_q[idx_q]
             | (blink_q[idx_q] & phase_q)
             | (lz_q & (idx_q != '0) & lead_zero[idx_q]);

        // Build the active-low form; a dark digit also kills its decimal point.
        seg_d = dark ? SEG_OFF : dec;
        dot_d = dark ? 1'b1 : ~dp_q[idx_q];
        an_d  = '1;
        if (!dark) an_d[idx_q] = 1'b0;

        if (ACTIVE_LOW == 0) begin
            seg_d = ~seg_d;
            dot_d = ~dot_d;
            an_d  = ~an_d;
        end
    end

    always_ff @(posedge clk_17 or posedge rst) begin
        if (rst) begin
            idx_q       <= IDX_TOP;
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
            fs_q        <= 1'b0;
            bcd_q       <= '0;
            dp_q        <= '0;
            blank_q     <= '0;
            blink_q     <= '0;
            lz_q        <= 1'b0;
            seg_q       <= {7{INACT}};
            dot_q       <= INACT;
            an_q        <= {N_DIGITS{INACT}};
        end else begin
            seg_q <= seg_d;
            dot_q <= dot_d;
            an_q  <= an_d;
            if (wrap) begin
                idx_q   <= IDX_TOP;
                fs_q    <= 1'b1;
                bcd_q   <= bus_if.bcd_in;
                dp_q    <= bus_if.dp_mask;
                blank_q <= bus_if.blank_mask;
                blink_q <= bus_if.blink_mask;
                lz_q    <= bus_if.lz_en;
                // Phase flips on the wrap edge so the new frame starts in the new phase.
                if (frame_cnt_q == FRAME_LAST) begin
                    frame_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
            end else begin
                idx_q <= idx_q - 1'b1;
                fs_q  <= 1'b0;
            end
        end
    end

    assign bus_if.seg         = seg_q;
    assign bus_if.dot         = dot_q;
    assign bus_if.an          = an_q;
    assign bus_if.frame_start = fs_q;

endmodule
